// File: rtl/frac_n_pkg.sv
// Shared constants and ratio clamp for the frac-N feedback divider and the DSM.
// The DSM output stage imports this package too, so both blocks agree on the
// legal ratio range.
package frac_n_pkg;

  localparam int unsigned DIV_W_DEF = 10;
  localparam int unsigned N_MIN_DEF = 16;
  localparam int unsigned N_MAX_DEF = 1023;
  localparam int unsigned N_RST_DEF = 248;

  // Saturate a requested ratio into [n_min, n_max].
  function automatic int unsigned clamp_ratio(input int unsigned r,
                                              input int unsigned n_min,
                                              input int unsigned n_max);
    if (r < n_min)      return n_min;
    else if (r > n_max) return n_max;
    else                return r;
  endfunction

endpackage

// File: rtl/frac_n_prog_divider_if.sv
// DSM <-> divider handshake bundle.
//   enable, div_ratio, clr_err                  : DSM -> divider
//   ratio_ack, div_pulse, freq_out, ratio_clamped : divider -> DSM / PFD
interface frac_n_prog_divider_if
  import frac_n_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
);
  logic             enable;
  logic [DIV_W-1:0] div_ratio;
  logic             clr_err;
  logic             ratio_ack;
  logic             div_pulse;
  logic             freq_out;
  logic             ratio_clamped;

  modport master (output enable, div_ratio, clr_err,
                  input  ratio_ack, div_pulse, freq_out, ratio_clamped);
  modport slave  (input  enable, div_ratio, clr_err,
                  output ratio_ack, div_pulse, freq_out, ratio_clamped);
endinterface

// File: rtl/frac_n_ratio_clamp.sv
// Combinational ratio clamp.
//   div_ratio : requested ratio
//   ratio_nc  : ratio saturated into [N_MIN, N_MAX]
//   clamp_hit : 1 when ratio_nc differs from the request
module frac_n_ratio_clamp
  import frac_n_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned N_MIN = N_MIN_DEF,
  parameter int unsigned N_MAX = N_MAX_DEF
) (
  input  logic [DIV_W-1:0] div_ratio,
  output logic [DIV_W-1:0] ratio_nc,
  output logic             clamp_hit
);

  always_comb begin
    ratio_nc  = DIV_W'(clamp_ratio(32'(div_ratio), N_MIN, N_MAX));
    clamp_hit = (ratio_nc != div_ratio);
  end

endmodule

// File: rtl/frac_n_prog_divider.sv
// Programmable integer-N feedback divider for the frac-N PLL.
//   freq_in  : VCO clock, all state on its rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of the DSM handshake (enable, div_ratio, clr_err in;
//              ratio_ack, div_pulse, freq_out, ratio_clamped out, all registered)
// A new ratio is taken whenever the down-counter sits at zero; the period is
// then exactly the loaded N enabled cycles, freq_out high for floor(N/2).
module frac_n_prog_divider
  import frac_n_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned N_MIN = N_MIN_DEF,
  parameter int unsigned N_MAX = N_MAX_DEF,
  parameter int unsigned N_RST = N_RST_DEF
) (
  input  logic                  freq_in,
  input  logic                  reset_n,
  frac_n_prog_divider_if.slave  bus
);

  logic [DIV_W-1:0] cnt, n_cur;
  logic [DIV_W-1:0] ratio_nc, cnt_dec, hi_thr;
  logic             clamp_hit;
  logic             pulse_q, ack_q, fo_q, clamp_q;
  logic             load;

  frac_n_ratio_clamp #(
    .DIV_W (DIV_W),
    .N_MIN (N_MIN),
    .N_MAX (N_MAX)
  ) u_clamp (
    .div_ratio (bus.div_ratio),
    .ratio_nc  (ratio_nc),
    .clamp_hit (clamp_hit)
  );

  assign load    = bus.enable && (cnt == '0);
  assign cnt_dec = cnt - DIV_W'(1);
  // Low phase is ceil(N/2) counts: high while the next count is >= that.
  assign hi_thr  = n_cur - (n_cur >> 1);

  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      n_cur   <= DIV_W'(N_RST);
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      fo_q    <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      if (bus.enable) begin
        if (load) begin
          n_cur   <= ratio_nc;
          cnt     <= ratio_nc - DIV_W'(1);
          pulse_q <= 1'b1;
          ack_q   <= 1'b1;
          fo_q    <= 1'b1;
        end else begin
          cnt     <= cnt_dec;
          pulse_q <= 1'b0;
          ack_q   <= 1'b0;
          fo_q    <= (cnt_dec >= hi_thr);
        end
      end else begin
        // Frozen: counter, ratio and duty level hold; strobes drop.
        pulse_q <= 1'b0;
        ack_q   <= 1'b0;
      end
      // A clamping load beats a simultaneous clear.
      if (load && clamp_hit) clamp_q <= 1'b1;
      else if (bus.clr_err)  clamp_q <= 1'b0;
    end
  end

  assign bus.div_pulse     = pulse_q;
  assign bus.ratio_ack     = ack_q;
  assign bus.freq_out      = fo_q;
  assign bus.ratio_clamped = clamp_q;

endmodule
